prog_counter: RTL

Program counter for the specialized processor, directly downstream of the branch-offset controller. Each cycle it consumes the signed `target` offset, either advancing by one or adding the offset when a branch is taken. It owns the start/run/done program sequencing: it loads the entry address of the selected program and reports completion to the testbench. `prog_ctr` drives instruction-ROM addressing.

---
 rtl/prog_counter.sv | 129 ++++++++++++
 1 files changed

// File: rtl/prog_counter.sv
// Program counter with start/run/done sequencing; relative branches add a signed offset.
// Optional out-of-range branch detection is compiled in with `define PC_BOUNDS_CHECK_EN.
module prog_counter #(
    parameter int             D        = 12,
    parameter logic [D-1:0]   P1_START = '0,
    parameter logic [D-1:0]   P2_START = D'(256),
    parameter logic [D-1:0]   P3_START = D'(512),
    parameter int             PROG_LEN = 4096
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         start,
    input  logic [1:0]   prog_sel,
    input  logic         branch,
    input  logic [D-1:0] target,
    input  logic         stall,
    input  logic         halt,
    output logic [D-1:0] prog_ctr,
    output logic         running,
    output logic         done,
    output logic         fault,
    // Sequencer state for checkers: 0 = IDLE, 1 = RUN, 2 = DONE.
    output logic [1:0]   state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state;
    logic [D-1:0] entry_addr;
    logic [D-1:0] pc_next;
    logic         out_of_range;

    always_comb begin
        entry_addr = '0;
        case (prog_sel)
            2'd0:    entry_addr = P1_START;
            2'd1:    entry_addr = P2_START;
            2'd2:    entry_addr = P3_START;
            default: entry_addr = '0;
        endcase
    end

`ifdef PC_BOUNDS_CHECK_EN
    localparam logic signed [D:0] LAST_ADDR = (D+1)'(PROG_LEN - 1);

    logic signed [D:0] next_wide;

    // Sum at D+1 bits with the offset sign-extended so under/overflow is visible.
    always_comb begin
        next_wide    = '0;
        out_of_range = 1'b0;
        if (branch) begin
            next_wide = $signed({1'b0, prog_ctr}) + $signed({target[D-1], target});
        end else begin
            next_wide = $signed({1'b0, prog_ctr}) + $signed((D+1)'(1));
        end
        out_of_range = next_wide[D] || (next_wide > LAST_ADDR);
        pc_next      = next_wide[D-1:0];
    end
`else
    // Truncated D-bit add: wraps modulo 2^D.
    always_comb begin
        out_of_range = 1'b0;
        pc_next      = branch ? (prog_ctr + target) : (prog_ctr + D'(1));
    end
`endif

`ifdef PC_BOUNDS_CHECK_EN
    logic fault_q;
    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= IDLE;
            prog_ctr <= '0;
            running  <= 1'b0;
            done     <= 1'b0;
`ifdef PC_BOUNDS_CHECK_EN
            fault_q  <= 1'b0;
`endif
        end else if (start) begin
            state    <= RUN;
            prog_ctr <= entry_addr;
            running  <= 1'b1;
            done     <= 1'b0;
`ifdef PC_BOUNDS_CHECK_EN
            fault_q  <= 1'b0;
`endif
        end else begin
            case (state)
                RUN: begin
                    if (halt) begin
                        state   <= DONE;
                        running <= 1'b0;
                        done    <= 1'b1;
                    end else if (!stall) begin
                        if (out_of_range) begin
                            // Suppress the update and park in DONE with the fault flag raised.
                            state   <= DONE;
                            running <= 1'b0;
                            done    <= 1'b1;
`ifdef PC_BOUNDS_CHECK_EN
                            fault_q <= 1'b1;
`endif
                        end else begin
                            prog_ctr <= pc_next;
                        end
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign state_dbg = state;

endmodule
